spi_frame_loader: RTL and testbench

- Upstream feeder for ledDriver.
- Receives one LED frame from the AVR over a SPI slave link (mode 0, MSB first) into a staging buffer.
- On a well-formed frame, copies the staging buffer to the parallel frame bus and pulses start.
- Frames arriving while the driver is busy are held until finish, so the frame bus stays stable during transmission.

---
 rtl/spi_frame_loader_if.sv | 22 ++
 rtl/spi_frame_loader.sv | 112 +++++++++++
 tb/tb_spi_frame_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_loader_if.sv
// SPI link from the AVR plus the frame bus and handshake toward ledDriver.
interface spi_frame_loader_if #(parameter int NUM_LEDS = 1);
    logic                    sck;
    logic                    mosi;
    logic                    cs_n;
    logic [NUM_LEDS*24-1:0]  outData;
    logic                    start;
    logic                    finish;
    logic                    busy;
    logic                    frame_err;
    logic                    dropped;

    modport master (
        output sck, mosi, cs_n, finish,
        input  outData, start, busy, frame_err, dropped
    );

    modport slave (
        input  sck, mosi, cs_n, finish,
        output outData, start, busy, frame_err, dropped
    );
endinterface

// File: rtl/spi_frame_loader.sv
// Receives one LED frame over SPI mode 0 into a staging buffer and hands it
// to ledDriver, holding frames that arrive while the driver is transmitting.
module spi_frame_loader #(
    parameter int NUM_LEDS = 1
) (
    input  logic               clk,
    input  logic               reset,
    spi_frame_loader_if.slave  bus
);
    localparam int NUM_BYTES = NUM_LEDS * 3;
    localparam int WIDTH     = NUM_LEDS * 24;
    localparam int CNT_W     = $clog2(NUM_BYTES + 2);

    typedef enum logic [2:0] {IDLE, RECV, CHECK, PENDING, LAUNCH} state_t;

    state_t            state, next_state;
    logic [2:0]        sck_sync;
    logic [2:0]        cs_sync;
    logic [1:0]        mosi_sync;
    logic [6:0]        shift_reg;
    logic [2:0]        bit_cnt;
    logic [CNT_W-1:0]  byte_cnt;
    logic [7:0]        staging [NUM_BYTES];
    logic              pending;
    logic              sck_rise, cs_fall, cs_rise, frame_ok;

    // cs_n chain resets to "low" so a select already held low at release is
    // never seen as a falling edge; the AVR must deselect first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
        end else begin
            sck_sync  <= {sck_sync[1:0], bus.sck};
            cs_sync   <= {cs_sync[1:0], bus.cs_n};
            mosi_sync <= {mosi_sync[0], bus.mosi};
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign cs_fall  = ~cs_sync[1] & cs_sync[2];
    assign cs_rise  = cs_sync[1] & ~cs_sync[2];
    assign frame_ok = (byte_cnt == CNT_W'(NUM_BYTES)) && (bit_cnt == 3'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cs_fall) next_state = RECV;
            RECV:    if (cs_rise) next_state = CHECK;
            CHECK:   if (!frame_ok)     next_state = IDLE;
                     else if (bus.busy) next_state = PENDING;
                     else               next_state = LAUNCH;
            // A new frame starting wins over launching the held one.
            PENDING: if (cs_fall)       next_state = RECV;
                     else if (!bus.busy) next_state = LAUNCH;
            LAUNCH:  if (cs_fall) next_state = RECV;
                     else         next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.start     = (state == LAUNCH);
        bus.frame_err = (state == CHECK) && !frame_ok;
        bus.dropped   = pending && (next_state == RECV);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            for (int k = 0; k < NUM_BYTES; k++) staging[k] <= '0;
        end else if (state != RECV && next_state == RECV) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
        end else if (state == RECV && sck_rise) begin
            shift_reg <= {shift_reg[5:0], mosi_sync[1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
                for (int k = 0; k < NUM_BYTES; k++)
                    if (byte_cnt == CNT_W'(k)) staging[k] <= {shift_reg, mosi_sync[1]};
                // Saturating one past a full frame marks overflow.
                if (byte_cnt != CNT_W'(NUM_BYTES + 1)) byte_cnt <= byte_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
            bus.busy    <= 1'b0;
            bus.outData <= '0;
        end else begin
            pending <= (next_state == PENDING);
            // Loaded on entry to LAUNCH so the frame is already on the bus with start.
            if (next_state == LAUNCH) begin
                bus.busy <= 1'b1;
                for (int k = 0; k < NUM_BYTES; k++)
                    bus.outData[WIDTH-1-8*k -: 8] <= staging[k];
            end else if (bus.finish && state != LAUNCH) begin
                bus.busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_frame_loader.sv
// Scoreboard bench for spi_frame_loader with a frame-level reference model.
`timescale 1ns/1ps
module tb_spi_frame_loader;
    localparam int NL = 2;
    localparam int NB = NL * 3;
    localparam int W  = NL * 24;

    typedef struct {
        logic [W-1:0] data;
        bit           from_pending;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    spi_frame_loader_if #(.NUM_LEDS(NL)) bus();
    spi_frame_loader #(.NUM_LEDS(NL)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #25 clk = ~clk;

    exp_t         exp_q[$];
    int           tests = 0, fails = 0;
    int           cyc = 0;
    int           cs_rise_cyc = 0, finish_cyc = 0;
    int           err_seen = 0, drop_seen = 0;
    int           exp_err = 0, exp_drop = 0;
    logic [W-1:0] model_out = '0, pend_data = '0, launched = '0;
    bit           model_busy = 0, model_pending = 0;
    logic [7:0]   fb [9];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_outData"}, bus.outData, model_out);
        check({tag, "_busy"}, W'(bus.busy), W'(model_busy));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops the scoreboard on every start and watches frame stability.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (bus.frame_err) err_seen++;
            if (bus.dropped)   drop_seen++;
            if (bus.start) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_start: start seen with outData %h, required no start", bus.outData);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("start_data", bus.outData, e.data);
                    check("busy_at_start", W'(bus.busy), W'(1));
                    if (e.from_pending) begin
                        check("finish_to_start", W'(cyc - finish_cyc), W'(2));
                    end else begin
                        tests++;
                        if (cyc - cs_rise_cyc < 3 || cyc - cs_rise_cyc > 6) begin
                            fails++;
                            $display("FAIL cs_to_start: got %0d cycles, required 3..6", cyc - cs_rise_cyc);
                        end
                    end
                    launched = e.data;
                end
            end else if (bus.busy) begin
                check("hold_outData", bus.outData, launched);
            end
        end
    end

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            bus.mosi = b[i];
            #100 bus.sck = 1'b1;
            #100 bus.sck = 1'b0;
        end
    endtask

    // Sends fb[0..n-1] plus xb leading bits of fb[n]; model decides the outcome.
    task automatic send_frame(input int n, input int xb);
        logic [W-1:0] d;
        exp_t e;
        @(negedge clk);
        if (model_pending) begin
            exp_drop++;
            model_pending = 0;
        end
        bus.cs_n = 1'b0;
        #100;
        for (int k = 0; k < n; k++) spi_bits(fb[k], 8);
        if (xb > 0) spi_bits(fb[n], xb);
        #100 bus.cs_n = 1'b1;
        cs_rise_cyc = cyc;
        d = '0;
        for (int k = 0; k < NB; k++) d[W-1-8*k -: 8] = fb[k];
        if (n != NB || xb != 0) begin
            exp_err++;
        end else if (model_busy) begin
            model_pending = 1;
            pend_data = d;
        end else begin
            e.data = d; e.from_pending = 0;
            exp_q.push_back(e);
            model_busy = 1;
            model_out = d;
        end
        repeat (20) @(negedge clk);
        check_state("frame");
    endtask

    task automatic do_finish();
        exp_t e;
        @(negedge clk);
        bus.finish = 1'b1;
        finish_cyc = cyc;
        @(negedge clk);
        bus.finish = 1'b0;
        if (model_busy) begin
            model_busy = 0;
            if (model_pending) begin
                model_pending = 0;
                model_busy = 1;
                model_out = pend_data;
                e.data = pend_data; e.from_pending = 1;
                exp_q.push_back(e);
            end
        end
        repeat (10) @(negedge clk);
        check_state("finish");
    endtask

    initial begin
        int n, xb, op, err_before;
        bus.sck = 1'b0; bus.mosi = 1'b0; bus.cs_n = 1'b1; bus.finish = 1'b0;
        #10 reset = 1'b1;
        #20;
        check("rst_outData", bus.outData, '0);
        check("rst_start", W'(bus.start), '0);
        check("rst_busy", W'(bus.busy), '0);
        check("rst_frame_err", W'(bus.frame_err), '0);
        check("rst_dropped", W'(bus.dropped), '0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int k = 0; k < 9; k++) fb[k] = 8'(8'h11 * (k + 1));
        send_frame(6, 0);
        check("first_frame", bus.outData, 48'h112233445566);
        check("first_no_err", W'(err_seen), W'(0));

        send_frame(5, 0);
        send_frame(7, 0);
        check("short_long_errs", W'(err_seen), W'(2));
        send_frame(6, 3);
        check("partial_errs", W'(err_seen), W'(3));
        check("kept_frame", bus.outData, 48'h112233445566);

        for (int k = 0; k < 9; k++) fb[k] = 8'hAA;
        send_frame(6, 0);
        check("held_while_busy", bus.outData, 48'h112233445566);
        do_finish();
        check("pending_launch", bus.outData, 48'hAAAAAAAAAAAA);

        for (int k = 0; k < 9; k++) fb[k] = 8'h0F;
        send_frame(6, 0);
        for (int k = 0; k < 9; k++) fb[k] = 8'h5A;
        send_frame(6, 0);
        check("drop_count", W'(drop_seen), W'(1));
        do_finish();
        check("latest_wins", bus.outData, 48'h5A5A5A5A5A5A);
        do_finish();

        for (int k = 0; k < 9; k++) fb[k] = 8'(8'hC0 + k);
        @(negedge clk);
        bus.cs_n = 1'b0;
        #100;
        for (int k = 0; k < 3; k++) spi_bits(fb[k], 8);
        #30 reset = 1'b1;
        #1;
        check("mid_rst_outData", bus.outData, '0);
        check("mid_rst_busy", W'(bus.busy), '0);
        check("mid_rst_start", W'(bus.start), '0);
        model_busy = 0; model_pending = 0; model_out = '0; launched = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        err_before = err_seen;
        #100;
        spi_bits(fb[3], 8);
        spi_bits(fb[4], 8);
        #100 bus.cs_n = 1'b1;
        repeat (20) @(negedge clk);
        check_state("post_rst");
        check("post_rst_no_err", W'(err_seen), W'(err_before));
        for (int k = 0; k < 9; k++) fb[k] = 8'(8'h90 + k);
        send_frame(6, 0);
        check("post_rst_frame", bus.outData, 48'h909192939495);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 9);
            for (int k = 0; k < 9; k++) fb[k] = 8'($urandom);
            if (op < 5) begin
                send_frame(NB, 0);
            end else if (op < 7) begin
                n  = $urandom_range(0, 8);
                xb = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
                if (n == NB && xb == 0) xb = 2;
                send_frame(n, xb);
            end else begin
                do_finish();
            end
        end
        do_finish();

        check("total_frame_err", W'(err_seen), W'(exp_err));
        check("total_dropped", W'(drop_seen), W'(exp_drop));
        check("scoreboard_empty", W'(exp_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
